// File: rtl/instr_encoder_loader_pkg.sv
// Shared types and constants for the instruction encoder/loader: op enum, FSM states,
// error codes, fixed opcode fields and the immediate range helpers.
package encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADDI  = 4'd0,
    OP_ADDS  = 4'd1,
    OP_SUBS  = 4'd2,
    OP_B     = 4'd3,
    OP_CBZ   = 4'd4,
    OP_STUR  = 4'd5,
    OP_LDUR  = 4'd6,
    OP_BLT   = 4'd7,
    OP_MOVZ  = 4'd8,
    OP_MOVK  = 4'd9,
    OP_STURB = 4'd10,
    OP_LDURB = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_IMM_RANGE = 2'd3;

  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STURB = 11'b00111000000;
  localparam logic [10:0] OPC_LDURB = 11'b00111000010;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_BLT   = 8'b01010100;
  localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OPC_MOVK  = 9'b111100101;
  // o0 bit plus the LT condition nibble
  localparam logic [4:0]  COND_LT   = 5'b01011;

  function automatic logic imm_signed_bad(input logic [25:0] imm, input int unsigned w);
    logic [25:0] sext;
    sext = 26'($signed(imm << (26 - w)) >>> (26 - w));
    return sext != imm;
  endfunction

  function automatic logic imm_unsigned_bad(input logic [25:0] imm, input int unsigned w);
    return (imm >> w) != 26'd0;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Instruction beat stream plus instruction-memory write port of the encoder/loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [25:0]       in_imm;
  logic [1:0]        in_shift;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wr_data;

  modport master (
    output in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm, in_shift,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_last, in_op, in_rd, in_rn, in_rm, in_imm, in_shift,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/instr_encoder_loader_word_encode.sv
// Combinational op + fields -> 32-bit machine word, with illegal-op and immediate-range flags.
// Build macro IMM_RANGE_CHECK_EN enables range_bad; without it immediates are silently truncated.
module instr_word_encode
  import encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [25:0] imm,
  input  logic [1:0]  shift,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_bad
);

  always_comb begin
    word    = 32'd0;
    illegal = 1'b0;
    case (op)
      OP_ADDI:  word = {OPC_ADDI, imm[11:0], rn, rd};
      OP_ADDS:  word = {OPC_ADDS, rm, 6'd0, rn, rd};
      OP_SUBS:  word = {OPC_SUBS, rm, 6'd0, rn, rd};
      OP_B:     word = {OPC_B, imm[25:0]};
      OP_CBZ:   word = {OPC_CBZ, imm[18:0], rd};
      OP_BLT:   word = {OPC_BLT, imm[18:0], COND_LT};
      OP_STUR:  word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      OP_LDUR:  word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STURB: word = {OPC_STURB, imm[8:0], 2'b00, rn, rd};
      OP_LDURB: word = {OPC_LDURB, imm[8:0], 2'b00, rn, rd};
      OP_MOVZ:  word = {OPC_MOVZ, shift, imm[15:0], rd};
      OP_MOVK:  word = {OPC_MOVK, shift, imm[15:0], rd};
      default:  illegal = 1'b1;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  always_comb begin
    range_bad = 1'b0;
    case (op)
      OP_ADDI:                          range_bad = imm_unsigned_bad(imm, 12);
      OP_MOVZ, OP_MOVK:                 range_bad = imm_unsigned_bad(imm, 16);
      OP_CBZ, OP_BLT:                   range_bad = imm_signed_bad(imm, 19);
      OP_STUR, OP_LDUR, OP_STURB, OP_LDURB: range_bad = imm_signed_bad(imm, 9);
      default:                          range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction beats, encodes them and writes them sequentially into instruction
// memory (one word/cycle, one register stage). Build macro IMM_RANGE_CHECK_EN adds range aborts.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | accepting beats; each good beat becomes a write next cycle
// S_FLUSH | final beat's write is on the port
// S_DONE  | session finished cleanly (done)
// S_ERR   | session aborted, err_code holds the cause
module instr_encoder_loader
  import encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  instr_encoder_loader_if.slave  bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_e            state, state_next;
  logic [ADDR_W-1:0] ptr, addr_q;
  logic [31:0]       word, data_q;
  logic              illegal, range_bad;
  logic              wr_q, ready, accept, load, abort;
  logic [1:0]        abort_code;

  instr_word_encode u_encode (
    .op        (bus.in_op),
    .rd        (bus.in_rd),
    .rn        (bus.in_rn),
    .rm        (bus.in_rm),
    .imm       (bus.in_imm),
    .shift     (bus.in_shift),
    .word      (word),
    .illegal   (illegal),
    .range_bad (range_bad)
  );

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_NONE;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        ready = (count < CNT_W'(DEPTH));
        if (bus.in_valid && !ready) begin
          abort      = 1'b1;
          abort_code = ERR_OVERFLOW;
        end else if (bus.in_valid) begin
          if (illegal) begin
            abort      = 1'b1;
            abort_code = ERR_ILLEGAL;
          end else if (range_bad) begin
            abort      = 1'b1;
            abort_code = ERR_IMM_RANGE;
          end else begin
            accept = 1'b1;
            if (bus.in_last) state_next = S_FLUSH;
          end
        end
        if (abort) state_next = S_ERR;
      end
      S_FLUSH: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ptr      <= '0;
      count    <= '0;
      err_code <= ERR_NONE;
    end else begin
      wr_q <= accept;
      if (load) begin
        ptr      <= base_addr & ~ADDR_W'(3);
        count    <= '0;
        err_code <= ERR_NONE;
      end
      if (accept) begin
        addr_q <= ptr;
        data_q <= word;
        ptr    <= ptr + ADDR_W'(4);
        count  <= count + CNT_W'(1);
      end
      if (abort) err_code <= abort_code;
    end
  end

  // A write still on the port when reset arrives is dropped immediately.
  assign bus.mem_wr_en   = wr_q & ~reset;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = data_q;
  assign bus.in_ready    = ready;
  assign busy            = (state == S_RUN) || (state == S_FLUSH);
  assign done            = (state == S_DONE);
  assign err             = (state == S_ERR);

endmodule
